// File: rtl/id_issue_buffer.sv
// Decode-to-issue FIFO: holds decoded instructions between ID and issue, with a
// throttle that keeps at most one control-flow instruction buffered at a time.

package config_pkg;
    typedef struct packed {
        logic [31:0] nr_commit_ports;
        logic [31:0] xlen;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module id_issue_buffer #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter type scoreboard_entry_t = logic,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  scoreboard_entry_t          in_sbe_i,
    input  logic [31:0]                in_orig_instr_i,
    input  logic                       in_is_ctrl_flow_i,
    output logic                       out_valid_o,
    input  logic                       out_ack_i,
    output scoreboard_entry_t          out_sbe_o,
    output logic [31:0]                out_orig_instr_o,
    output logic                       out_is_ctrl_flow_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("id_issue_buffer: DEPTH must be a power of two in 2..8");
    end

    scoreboard_entry_t sbe_q   [DEPTH];
    scoreboard_entry_t sbe_d   [DEPTH];
    logic [31:0]       instr_q [DEPTH];
    logic [31:0]       instr_d [DEPTH];
    logic              cf_q    [DEPTH];
    logic              cf_d    [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cf_cnt_q, cf_cnt_d;

    logic              push;
    logic              pop;
    logic              space;
    logic              cf_pending;
    logic              cf_block;

    // Head is read straight out of storage; nothing registered on the output side.
    assign out_sbe_o          = sbe_q[rd_ptr_q];
    assign out_orig_instr_o   = instr_q[rd_ptr_q];
    assign out_is_ctrl_flow_o = cf_q[rd_ptr_q];
    assign count_o            = count_q;

    assign out_valid_o = (count_q != '0) & ~flush_i;
    assign pop         = out_valid_o & out_ack_i;
    assign space       = (count_q < CNT_W'(DEPTH)) | pop;

    // A branch leaving this cycle frees the single control-flow slot for the incoming one.
    assign cf_pending  = cf_cnt_q & ~(pop & out_is_ctrl_flow_o);
    assign cf_block    = in_is_ctrl_flow_i & cf_pending;
    assign in_ready_o  = space & ~cf_block & ~flush_i;
    assign push        = in_valid_i & in_ready_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cf_cnt_d = cf_cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            cf_cnt_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            cf_cnt_d = cf_pending | (push & in_is_ctrl_flow_i);
        end
    end

    always_comb begin
        sbe_d   = sbe_q;
        instr_d = instr_q;
        cf_d    = cf_q;
        if (push) begin
            sbe_d[wr_ptr_q]   = in_sbe_i;
            instr_d[wr_ptr_q] = in_orig_instr_i;
            cf_d[wr_ptr_q]    = in_is_ctrl_flow_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cf_cnt_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cf_cnt_q <= cf_cnt_d;
        end
    end

    // Storage is cleared on reset so the head outputs read as zero while rst_i is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                sbe_q[i]   <= '0;
                instr_q[i] <= '0;
                cf_q[i]    <= 1'b0;
            end
        end else begin
            sbe_q   <= sbe_d;
            instr_q <= instr_d;
            cf_q    <= cf_d;
        end
    end

endmodule

// File: tb/tb_id_issue_buffer.sv
// Scoreboard bench for id_issue_buffer: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.

module tb_id_issue_buffer;

    localparam int DEPTH = 2;

    typedef struct {
        logic [15:0] sbe;
        logic [31:0] instr;
        logic        cf;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sbe;
    logic [31:0] in_instr;
    logic        in_cf;
    logic        out_valid;
    logic        out_ack;
    logic [15:0] out_sbe;
    logic [31:0] out_instr;
    logic        out_cf;
    logic [$clog2(DEPTH):0] count;

    int tests  = 0;
    int errors = 0;
    entry_t model_q[$];

    always #5 clk = ~clk;

    id_issue_buffer #(
        .scoreboard_entry_t (logic [15:0]),
        .DEPTH              (DEPTH)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .flush_i            (flush),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .in_sbe_i           (in_sbe),
        .in_orig_instr_i    (in_instr),
        .in_is_ctrl_flow_i  (in_cf),
        .out_valid_o        (out_valid),
        .out_ack_i          (out_ack),
        .out_sbe_o          (out_sbe),
        .out_orig_instr_o   (out_instr),
        .out_is_ctrl_flow_o (out_cf),
        .count_o            (count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT against the model each cycle, then advances the model.
    always @(negedge clk) begin
        bit     m_valid, m_pop, m_ready;
        int     cf_left;
        entry_t e;
        if (rst) begin
            model_q.delete();
            chk("rst_valid", 64'(out_valid), 64'(0));
            chk("rst_count", 64'(count), 64'(0));
            chk("rst_ready", 64'(in_ready), 64'(!flush));
        end else begin
            m_valid = (model_q.size() != 0) && !flush;
            m_pop   = m_valid && out_ack;
            cf_left = 0;
            foreach (model_q[i]) cf_left += int'(model_q[i].cf);
            if (m_pop && model_q[0].cf) cf_left--;
            m_ready = !flush && ((model_q.size() < DEPTH) || m_pop) && !(in_cf && cf_left != 0);
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("in_ready", 64'(in_ready), 64'(m_ready));
            chk("count", 64'(count), 64'(model_q.size()));
            if (m_valid) begin
                chk("head_instr", 64'(out_instr), 64'(model_q[0].instr));
                chk("head_sbe", 64'(out_sbe), 64'(model_q[0].sbe));
                chk("head_cf", 64'(out_cf), 64'(model_q[0].cf));
            end
            $display("[TB] t=%0t v=%0b a=%0b f=%0b cf=%0b instr=%h -> rdy=%0b oval=%0b out=%h cnt=%0d",
                     $time, in_valid, out_ack, flush, in_cf, in_instr, in_ready, out_valid, out_instr, count);
            if (flush) begin
                model_q.delete();
            end else begin
                if (m_pop) void'(model_q.pop_front());
                if (in_valid && m_ready) begin
                    e.sbe   = in_sbe;
                    e.instr = in_instr;
                    e.cf    = in_cf;
                    model_q.push_back(e);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] instr, input logic c,
                        input logic a, input logic f);
        in_valid = v;
        in_instr = instr;
        in_cf    = c;
        out_ack  = a;
        flush    = f;
        in_sbe   = 16'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_zero_checks();
        chk("rst_now_valid", 64'(out_valid), 64'(0));
        chk("rst_now_count", 64'(count), 64'(0));
        chk("rst_now_instr", 64'(out_instr), 64'(0));
        chk("rst_now_sbe", 64'(out_sbe), 64'(0));
        chk("rst_now_cf", 64'(out_cf), 64'(0));
        chk("rst_now_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sbe = '0;
        in_instr = '0; in_cf = 1'b1; out_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_zero_checks();
        rst = 1'b0;

        // Fill then drain
        step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hdead_0001, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Full pass-through
        step(1'b1, 32'h0000_1001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_1002, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_1003, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Control-flow throttle
        step(1'b1, 32'h0000_0063, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0463, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0463, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Flush with concurrent push and ack
        step(1'b1, 32'h0000_2001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_2002, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0000_2003, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Pointer wrap: back-to-back push/pop pairs
        step(1'b1, 32'h0000_3000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 2 * DEPTH + 1; i++)
            step(1'b1, 32'h0000_3000 + 32'(i), 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Asynchronous reset in the middle of a cycle with one entry buffered
        step(1'b1, 32'h0000_4001, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0; in_cf = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        reset_zero_checks();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0,
                 ($urandom % 2) == 1, ($urandom % 25) == 0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
